// File: rtl/instr_issue_if.sv
// rtl/instr_issue_if.sv - instruction memory read port and decoded-op handshake bundle
interface instr_issue_if;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  opcode;
    logic [3:0]  rd_idx;
    logic [3:0]  rs_idx;
    logic        op_valid;
    logic        op_ready;

    modport master (
        output imem_rd, imem_addr, opcode, rd_idx, rs_idx, op_valid,
        input  imem_data, op_ready
    );

    modport slave (
        input  imem_rd, imem_addr, opcode, rd_idx, rs_idx, op_valid,
        output imem_data, op_ready
    );
endinterface

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - fetch/decode/issue sequencer; define INSTR_ISSUE_ILLEGAL_TRAP_EN to halt on illegal opcodes
module instr_issue (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    instr_issue_if.master  bus,
    output logic [7:0]     pc,
    output logic           halted,
    output logic [15:0]    issued_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [7:0] OP_LAST_LEGAL = 8'h04;
    localparam logic [7:0] OP_HALT       = 8'hFF;

    logic [2:0]  state;
    logic [15:0] instr;
    logic [7:0]  mem_op;
    logic        mem_legal;
    logic        mem_halt;

    // Classify the word arriving from memory so the WAIT_MEM exit is known at capture time.
    assign mem_op    = bus.imem_data[15:8];
    assign mem_legal = (mem_op <= OP_LAST_LEGAL);
    assign mem_halt  = (mem_op == OP_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= 8'h00;
            issued_cnt <= 16'h0000;
            instr      <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    instr <= bus.imem_data;
                    if (mem_legal) begin
                        state <= S_ISSUE;
                    end else if (mem_halt) begin
                        state <= S_HALT;
                    end else begin
`ifdef INSTR_ISSUE_ILLEGAL_TRAP_EN
                        state <= S_HALT;
`else
                        pc    <= pc + 8'd1;
                        state <= S_FETCH;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus.op_ready) begin
                        pc    <= pc + 8'd1;
                        state <= S_FETCH;
                        if (issued_cnt != 16'hFFFF) begin
                            issued_cnt <= issued_cnt + 16'd1;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Fields come straight from the instruction register, so they cannot move while offered.
    assign bus.imem_rd   = (state == S_FETCH);
    assign bus.imem_addr = pc;
    assign bus.opcode    = instr[15:8];
    assign bus.rd_idx    = instr[7:4];
    assign bus.rs_idx    = instr[3:0];
    assign bus.op_valid  = (state == S_ISSUE);
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - scoreboard bench for instr_issue, both INSTR_ISSUE_ILLEGAL_TRAP_EN builds
module tb_instr_issue;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] issued_cnt;

    instr_issue_if bus_if ();

    instr_issue dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus_if),
        .pc         (pc),
        .halted     (halted),
        .issued_cnt (issued_cnt)
    );

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] sb_got;
    logic [15:0] sb_exp;
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus_if.imem_rd === 1'b1) begin
            bus_if.imem_data <= mem[bus_if.imem_addr];
        end
    end

    // Scoreboard: every handshake must match the next expected instruction.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus_if.op_valid === 1'b1 && bus_if.op_ready === 1'b1) begin
            sb_got = {bus_if.opcode, bus_if.rd_idx, bus_if.rs_idx};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_issue: got %h expected no issue", sb_got);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sb_got !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_issue: got %h expected %h", sb_got, sb_exp);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        bus_if.op_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic test_reset;
        fill_mem(16'hFF00);
        rst = 1'b1;
        start = 1'b1;
        bus_if.op_ready = 1'b1;
        tick;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h expected 00", pc); end
        checks++; if (issued_cnt !== 16'h0000) begin errors++; $display("FAIL rst_cnt: got %h expected 0000", issued_cnt); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (bus_if.op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %b expected 0", bus_if.op_valid); end
        checks++; if (bus_if.imem_rd !== 1'b0) begin errors++; $display("FAIL rst_imem_rd: got %b expected 0", bus_if.imem_rd); end
        checks++; if ({bus_if.opcode, bus_if.rd_idx, bus_if.rs_idx} !== 16'h0000) begin
            errors++; $display("FAIL rst_fields: got %h expected 0000", {bus_if.opcode, bus_if.rd_idx, bus_if.rs_idx});
        end
        do_reset;
    endtask

    task automatic test_basic;
        do_reset;
        fill_mem(16'hFF00);
        mem[0] = 16'h0212;
        mem[1] = 16'h0334;
        mem[2] = 16'hFF00;
        exp_q.push_back(16'h0212);
        exp_q.push_back(16'h0334);
        bus_if.op_ready = 1'b1;
        pulse_start;
        checks++; if (bus_if.imem_rd !== 1'b1 || bus_if.imem_addr !== 8'h00) begin
            errors++; $display("FAIL basic_first_fetch: got rd=%b addr=%h expected rd=1 addr=00", bus_if.imem_rd, bus_if.imem_addr);
        end
        tick;
        checks++; if (bus_if.op_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus_if.op_valid); end
        tick;
        checks++; if (bus_if.op_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_k3: got %b expected 1", bus_if.op_valid); end
        for (int n = 0; n < 40 && halted !== 1'b1; n++) tick;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halted: got %b expected 1", halted); end
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL basic_pc: got %h expected 02", pc); end
        checks++; if (issued_cnt !== 16'd2) begin errors++; $display("FAIL basic_cnt: got %0d expected 2", issued_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_stall;
        do_reset;
        fill_mem(16'hFF00);
        mem[0] = 16'h04AB;
        exp_q.push_back(16'h04AB);
        bus_if.op_ready = 1'b0;
        pulse_start;
        for (int n = 0; n < 10 && bus_if.op_valid !== 1'b1; n++) tick;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus_if.op_valid !== 1'b1 || {bus_if.opcode, bus_if.rd_idx, bus_if.rs_idx} !== 16'h04AB || pc !== 8'h00) begin
                errors++; $display("FAIL stall_hold: got v=%b f=%h pc=%h expected v=1 f=04ab pc=00",
                    bus_if.op_valid, {bus_if.opcode, bus_if.rd_idx, bus_if.rs_idx}, pc);
            end
            tick;
        end
        bus_if.op_ready = 1'b1;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL stall_pc_before: got %h expected 00", pc); end
        tick;
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL stall_pc_after: got %h expected 01", pc); end
        for (int n = 0; n < 20 && halted !== 1'b1; n++) tick;
        checks++; if (issued_cnt !== 16'd1 || halted !== 1'b1) begin
            errors++; $display("FAIL stall_end: got cnt=%0d halted=%b expected cnt=1 halted=1", issued_cnt, halted);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_pending: got %0d expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_illegal;
        do_reset;
        fill_mem(16'hFF00);
        mem[0] = 16'h0111;
        mem[1] = 16'h0755;
        mem[2] = 16'h0222;
        mem[3] = 16'hFF00;
        exp_q.push_back(16'h0111);
`ifndef INSTR_ISSUE_ILLEGAL_TRAP_EN
        exp_q.push_back(16'h0222);
`endif
        bus_if.op_ready = 1'b1;
        pulse_start;
        for (int n = 0; n < 20 && !(bus_if.imem_rd === 1'b1 && bus_if.imem_addr === 8'h01); n++) tick;
        checks++; if (bus_if.imem_rd !== 1'b1 || bus_if.imem_addr !== 8'h01) begin
            errors++; $display("FAIL ill_fetch1: got rd=%b addr=%h expected rd=1 addr=01", bus_if.imem_rd, bus_if.imem_addr);
        end
        tick;
        tick;
`ifdef INSTR_ISSUE_ILLEGAL_TRAP_EN
        checks++; if (halted !== 1'b1 || pc !== 8'h01 || bus_if.op_valid !== 1'b0) begin
            errors++; $display("FAIL ill_trap: got halted=%b pc=%h v=%b expected halted=1 pc=01 v=0", halted, pc, bus_if.op_valid);
        end
        for (int c = 0; c < 5; c++) tick;
        checks++; if (issued_cnt !== 16'd1 || pc !== 8'h01) begin
            errors++; $display("FAIL ill_trap_hold: got cnt=%0d pc=%h expected cnt=1 pc=01", issued_cnt, pc);
        end
`else
        checks++; if (bus_if.imem_rd !== 1'b1 || bus_if.imem_addr !== 8'h02 || bus_if.op_valid !== 1'b0) begin
            errors++; $display("FAIL ill_skip: got rd=%b addr=%h v=%b expected rd=1 addr=02 v=0",
                bus_if.imem_rd, bus_if.imem_addr, bus_if.op_valid);
        end
        for (int n = 0; n < 20 && halted !== 1'b1; n++) tick;
        checks++; if (issued_cnt !== 16'd2 || pc !== 8'h03 || halted !== 1'b1) begin
            errors++; $display("FAIL ill_skip_end: got cnt=%0d pc=%h halted=%b expected cnt=2 pc=03 halted=1", issued_cnt, pc, halted);
        end
`endif
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ill_pending: got %0d expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_wrap;
        do_reset;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i % 5), 8'(i)};
            exp_q.push_back({8'(i % 5), 8'(i)});
        end
        bus_if.op_ready = 1'b1;
        pulse_start;
        for (int n = 0; n < 2000 && !(pc === 8'hFF && bus_if.op_valid === 1'b1); n++) tick;
        checks++; if (pc !== 8'hFF || bus_if.op_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_reach: got pc=%h v=%b expected pc=ff v=1", pc, bus_if.op_valid);
        end
        tick;
        checks++; if (bus_if.imem_rd !== 1'b1 || bus_if.imem_addr !== 8'h00 || pc !== 8'h00) begin
            errors++; $display("FAIL wrap_addr: got rd=%b addr=%h pc=%h expected rd=1 addr=00 pc=00", bus_if.imem_rd, bus_if.imem_addr, pc);
        end
        checks++; if (issued_cnt !== 16'd256) begin errors++; $display("FAIL wrap_cnt: got %0d expected 256", issued_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d expected 0", exp_q.size()); end
        exp_q.delete();
        do_reset;
    endtask

    task automatic test_reset_mid;
        do_reset;
        fill_mem(16'hFF00);
        mem[0] = 16'h0356;
        bus_if.op_ready = 1'b0;
        pulse_start;
        for (int n = 0; n < 10 && bus_if.op_valid !== 1'b1; n++) tick;
        checks++; if (bus_if.op_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid: got %b expected 1", bus_if.op_valid); end
        rst = 1'b1;
        bus_if.op_ready = 1'b1;
        tick;
        rst = 1'b0;
        bus_if.op_ready = 1'b0;
        checks++; if (issued_cnt !== 16'd0 || pc !== 8'h00 || bus_if.op_valid !== 1'b0 || bus_if.opcode !== 8'h00) begin
            errors++; $display("FAIL rmid_state: got cnt=%0d pc=%h v=%b op=%h expected cnt=0 pc=00 v=0 op=00",
                issued_cnt, pc, bus_if.op_valid, bus_if.opcode);
        end
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus_if.imem_rd !== 1'b0 || halted !== 1'b0) begin
                errors++; $display("FAIL rmid_idle: got rd=%b halted=%b expected rd=0 halted=0", bus_if.imem_rd, halted);
            end
            tick;
        end
    endtask

    task automatic test_halt_start;
        do_reset;
        fill_mem(16'hFF00);
        bus_if.op_ready = 1'b1;
        pulse_start;
        for (int n = 0; n < 10 && halted !== 1'b1; n++) tick;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_reach: got %b expected 1", halted); end
        pulse_start;
        for (int c = 0; c < 10; c++) begin
            checks++; if (bus_if.imem_rd !== 1'b0 || halted !== 1'b1 || pc !== 8'h00) begin
                errors++; $display("FAIL halt_start: got rd=%b halted=%b pc=%h expected rd=0 halted=1 pc=00", bus_if.imem_rd, halted, pc);
            end
            tick;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus_if.op_ready = 1'b0;
        test_reset;
        test_basic;
        test_stall;
        test_illegal;
        test_wrap;
        test_reset_mid;
        test_halt_start;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
